// File: rtl/security_pkg.sv
`default_nettype none
// ============================================================================
// Module   : security_pkg
// Purpose  : Shared types and helpers for the keypad / security blocks.
// Revision : 1.0
// ============================================================================
package security_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        RESULT  = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    typedef logic [1:0] cmp_t;

    localparam cmp_t c_cmp_eq = 2'b00;
    localparam cmp_t c_cmp_gt = 2'b01;
    localparam cmp_t c_cmp_lt = 2'b10;

    // Bits needed for a counter that must hold values 0..max_value (never 0 wide).
    function automatic int cnt_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lockout_timer.sv
`default_nettype none
// ============================================================================
// Module   : lockout_timer
// Purpose  : Down-counter that stays active for exactly CYCLES clocks after start.
// Revision : 1.0
// ============================================================================
module lockout_timer
    import security_pkg::*;
#(
    parameter int CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic active,
    output logic done
);

    localparam int                 c_cnt_w = cnt_width(CYCLES);
    localparam logic [c_cnt_w-1:0] c_load  = c_cnt_w'(CYCLES);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (start) begin
            r_count <= c_load;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign active = (r_count != '0);
    // Marks the final active cycle so the owner can leave in step with the timer.
    assign done   = (r_count == c_cnt_w'(1));

endmodule
`default_nettype wire

// File: rtl/code_compare_seq.sv
`default_nettype none
// ============================================================================
// Module   : code_compare_seq
// Purpose  : Digit-serial keypad code comparator with failure count and lockout.
// Revision : 1.0
// ============================================================================
module code_compare_seq
    import security_pkg::*;
#(
    parameter int DIGIT_W     = 4,
    parameter int NUM_DIGITS  = 4,
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYCLES = 1000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic                              load_ref,
    input  logic [DIGIT_W*NUM_DIGITS-1:0]     ref_code,
    input  logic                              clear,
    input  logic                              digit_valid,
    input  logic [DIGIT_W-1:0]                digit_in,
    output logic                              digit_ready,
    output logic                              result_valid,
    output logic                              A_greater_B,
    output logic                              A_equal_B,
    output logic                              A_less_B,
    output logic [$clog2(MAX_FAILS+1)-1:0]    fail_count,
    output logic                              locked
);

    localparam int                  c_code_w   = DIGIT_W * NUM_DIGITS;
    localparam int                  c_idx_w    = cnt_width(NUM_DIGITS - 1);
    localparam int                  c_fc_w     = $clog2(MAX_FAILS + 1);
    localparam logic [c_idx_w-1:0]  c_last_idx = c_idx_w'(NUM_DIGITS - 1);
    localparam logic [c_fc_w-1:0]   c_fc_max   = c_fc_w'(MAX_FAILS);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_code_w-1:0]  r_ref;
    logic [c_idx_w-1:0]   r_idx;
    cmp_t                 r_dec;
    cmp_t                 w_cmp;
    cmp_t                 w_dec_nxt;
    logic [DIGIT_W-1:0]   w_ref_digit;
    logic                 w_entry;
    logic                 w_load;
    logic                 w_abort;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_lock_start;
    logic                 w_lock_active;
    logic                 w_lock_done;

    assign w_entry     = (r_state == IDLE) || (r_state == COLLECT);
    assign digit_ready = en & w_entry & ~clear;
    assign w_load      = en & load_ref & (r_state != LOCKED);
    assign w_abort     = w_entry & (clear | w_load);
    assign w_accept    = digit_valid & digit_ready & ~w_abort;
    assign w_last      = w_accept & (r_idx == c_last_idx);
    assign w_lock_start = (r_state == RESULT) && (fail_count == c_fc_max);

    // Digit k of the entry lines up with reference digit NUM_DIGITS-1-k.
    assign w_ref_digit = DIGIT_W'(r_ref >> (DIGIT_W * (int'(c_last_idx) - int'(r_idx))));

    always_comb begin
        w_cmp = c_cmp_eq;
        if (digit_in > w_ref_digit) begin
            w_cmp = c_cmp_gt;
        end else if (digit_in < w_ref_digit) begin
            w_cmp = c_cmp_lt;
        end
    end

    // The first differing digit decides; later digits cannot override it.
    assign w_dec_nxt = (r_dec == c_cmp_eq) ? w_cmp : r_dec;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, COLLECT: begin
                if (w_abort) begin
                    w_state_nxt = IDLE;
                end else if (w_last) begin
                    w_state_nxt = RESULT;
                end else if (w_accept) begin
                    w_state_nxt = COLLECT;
                end
            end
            RESULT: begin
                w_state_nxt = w_lock_start ? LOCKED : IDLE;
            end
            LOCKED: begin
                if (w_lock_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ref        <= '0;
            r_idx        <= '0;
            r_dec        <= c_cmp_eq;
            result_valid <= 1'b0;
            A_greater_B  <= 1'b0;
            A_equal_B    <= 1'b0;
            A_less_B     <= 1'b0;
            fail_count   <= '0;
        end else begin
            result_valid <= w_last;
            if (w_load) begin
                r_ref <= ref_code;
            end
            if (w_abort) begin
                r_idx <= '0;
                r_dec <= c_cmp_eq;
            end else if (w_last) begin
                r_idx       <= '0;
                r_dec       <= c_cmp_eq;
                A_greater_B <= (w_dec_nxt == c_cmp_gt);
                A_equal_B   <= (w_dec_nxt == c_cmp_eq);
                A_less_B    <= (w_dec_nxt == c_cmp_lt);
                if (w_dec_nxt == c_cmp_eq) begin
                    fail_count <= '0;
                end else if (fail_count != c_fc_max) begin
                    fail_count <= fail_count + 1'b1;
                end
            end else if (w_accept) begin
                r_idx <= r_idx + 1'b1;
                r_dec <= w_dec_nxt;
            end
            if ((r_state == LOCKED) && w_lock_done) begin
                fail_count <= '0;
            end
        end
    end

    lockout_timer #(
        .CYCLES (LOCK_CYCLES)
    ) u_lockout_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (w_lock_start),
        .active (w_lock_active),
        .done   (w_lock_done)
    );

    assign locked = w_lock_active;

endmodule
`default_nettype wire
